edge_pulse_gen: RTL

EDGE_PULSE_GEN -- requirements
Module: edge_pulse_gen

---
 rtl/edge_pulse_gen.sv | 117 +++++++++++
 1 files changed

// File: rtl/edge_pulse_gen.sv
// Programmable pulse-train generator: on accepting a request it emits
// `count` pulses of H cycles high followed by L cycles low, with registered
// rise/fall strobes, a busy flag and a one-cycle done strobe on completion.
module edge_pulse_gen #(
   parameter int LEN_W = 8,
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start_valid,
   output logic             start_ready,
   input  logic [LEN_W-1:0] high_len,
   input  logic [LEN_W-1:0] low_len,
   input  logic [CNT_W-1:0] count,
   input  logic             abort,
   output logic             sig,
   output logic             rise,
   output logic             fall,
   output logic             busy,
   output logic             done
);

   typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

   state_t             state;
   logic [LEN_W-1:0]   high_last;   // H-1 after zero-as-one clamp
   logic [LEN_W-1:0]   low_last;    // L-1 after zero-as-one clamp
   logic [LEN_W-1:0]   phase_cnt;   // cycles remaining in current phase, minus one
   logic [CNT_W-1:0]   pulse_cnt;   // pulses remaining, including the current one
   logic [LEN_W-1:0]   high_in_last;
   logic [LEN_W-1:0]   low_in_last;

   // Length 0 behaves as 1; storing len-1 lets the phase counter count down
   // to zero without ever needing an extra bit, so H=2^LEN_W-1 fits exactly.
   always_comb begin
      high_in_last = (high_len == '0) ? '0 : high_len - 1'b1;
      low_in_last  = (low_len  == '0) ? '0 : low_len  - 1'b1;
   end

   // Readiness and busy follow directly from the registered state.
   assign start_ready = (state == IDLE);
   assign busy        = (state != IDLE);

   // Main state machine with registered waveform and strobes.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         sig       <= 1'b0;
         rise      <= 1'b0;
         fall      <= 1'b0;
         done      <= 1'b0;
         high_last <= '0;
         low_last  <= '0;
         phase_cnt <= '0;
         pulse_cnt <= '0;
      end else begin
         rise <= 1'b0;
         fall <= 1'b0;
         done <= 1'b0;
         case (state)
            IDLE: begin
               // abort is deliberately ignored here
               if (start_valid) begin
                  if (count == '0) begin
                     done <= 1'b1;
                  end else begin
                     state     <= HIGH;
                     sig       <= 1'b1;
                     rise      <= 1'b1;
                     high_last <= high_in_last;
                     low_last  <= low_in_last;
                     phase_cnt <= high_in_last;
                     pulse_cnt <= count;
                  end
               end
            end
            HIGH: begin
               if (abort) begin
                  state <= IDLE;
                  sig   <= 1'b0;
                  fall  <= 1'b1;
               end else if (phase_cnt == '0) begin
                  state     <= LOW;
                  sig       <= 1'b0;
                  fall      <= 1'b1;
                  phase_cnt <= low_last;
               end else begin
                  phase_cnt <= phase_cnt - 1'b1;
               end
            end
            LOW: begin
               if (abort) begin
                  state <= IDLE;
               end else if (phase_cnt == '0) begin
                  if (pulse_cnt == {{(CNT_W-1){1'b0}}, 1'b1}) begin
                     state <= IDLE;
                     done  <= 1'b1;
                  end else begin
                     state     <= HIGH;
                     sig       <= 1'b1;
                     rise      <= 1'b1;
                     phase_cnt <= high_last;
                     pulse_cnt <= pulse_cnt - 1'b1;
                  end
               end else begin
                  phase_cnt <= phase_cnt - 1'b1;
               end
            end
            default: begin
               state <= IDLE;
               sig   <= 1'b0;
            end
         endcase
      end
   end

endmodule
